game_sequencer: RTL

- Frame-level game controller for the VGA shooter.
- Runs in the vgaclk domain. Converts vsync into a one-cycle frame tick and watches the per-pixel rocket and asteroid coverage to detect collisions.
- Tracks dodged asteroids, score, level and lives, and sequences the IDLE/PLAY/HIT/OVER game states.
- Drives freeze, flash, asteroid speed and respawn requests back to the sprite datapath.

---
 rtl/game_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: frame-level game controller (collisions, score, level, lives, game states)
module game_sequencer #(
  parameter int LIVES      = 3,
  parameter int HIT_FRAMES = 60,
  parameter int LEVEL_STEP = 8,
  parameter int MAX_LEVEL  = 7,
  parameter int SCORE_W    = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vsync,
  input  logic               blank_b,
  input  logic               rpixel,
  input  logic               apixel,
  input  logic               asteroid_done,
  input  logic               start_key,
  output logic [1:0]         state,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         level,
  output logic [3:0]         speed,
  output logic               freeze,
  output logic               flash,
  output logic               spawn_req,
  output logic               frame_tick
);
  localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, HIT = 2'd2, OVER = 2'd3;

  logic [2:0] vs;
  logic       tick, start_prev, start_ev, coll_l, done_l, spawn_n;
  logic [1:0] state_n;
  logic [7:0] timer, dodge_cnt;

  // vs[1:0] is the synchronizer, vs[2] remembers the previous synchronized level
  assign tick     = vs[2] & ~vs[1];
  assign start_ev = tick & start_key & ~start_prev;
  assign speed    = level + 4'd1;

  // vsync synchronizer and registered frame pulse
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vs         <= 3'b111;
      frame_tick <= 1'b0;
      spawn_req  <= 1'b0;
    end else begin
      vs         <= {vs[1:0], vsync};
      frame_tick <= tick;
      spawn_req  <= spawn_n;
    end

  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_n;

  // next-state decision, only on frame ticks
  always_comb begin
    state_n = state;
    if (tick)
      unique case (state)
        IDLE:    state_n = start_ev ? PLAY : IDLE;
        PLAY:    state_n = coll_l ? ((lives == 3'd1) ? OVER : HIT) : PLAY;
        HIT:     state_n = (timer == 8'd0) ? PLAY : HIT;
        default: state_n = start_ev ? IDLE : OVER;
      endcase
  end

  // state-derived outputs and the respawn request for the coming tick
  always_comb begin
    freeze  = state != PLAY;
    flash   = (state == HIT) & timer[2];
    spawn_n = tick & (((state == IDLE) & start_ev) |
                      ((state == PLAY) & ~coll_l & done_l) |
                      ((state == HIT) & (timer == 8'd0)));
  end

  // per-frame latches, counters and game bookkeeping
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      start_prev <= 1'b0;
      coll_l     <= 1'b0;
      done_l     <= 1'b0;
      lives      <= 3'(LIVES);
      score      <= '0;
      level      <= 4'd0;
      dodge_cnt  <= 8'd0;
      timer      <= 8'd0;
    end else if (tick) begin
      start_prev <= start_key;
      coll_l     <= 1'b0;
      done_l     <= 1'b0;
      unique case (state)
        PLAY:
          if (coll_l) begin
            lives <= lives - 3'd1;
            timer <= 8'(HIT_FRAMES - 1);
          end else if (done_l) begin
            score     <= (score == '1) ? score : score + 1'b1;
            dodge_cnt <= (dodge_cnt == 8'(LEVEL_STEP - 1)) ? 8'd0 : dodge_cnt + 8'd1;
            level     <= ((dodge_cnt == 8'(LEVEL_STEP - 1)) && (level < 4'(MAX_LEVEL))) ? level + 4'd1 : level;
          end
        HIT:
          timer <= (timer == 8'd0) ? timer : timer - 8'd1;
        OVER:
          if (start_ev) begin
            lives     <= 3'(LIVES);
            score     <= '0;
            level     <= 4'd0;
            dodge_cnt <= 8'd0;
          end
        default: ;
      endcase
    end else begin
      coll_l <= coll_l | ((state == PLAY) & rpixel & apixel & blank_b);
      done_l <= done_l | ((state == PLAY) & asteroid_done);
    end
endmodule
